// File: rtl/rom_pair_accum_if.sv
// Element result stream from rom_pair_accum to the LED/display stage.
// The master drives result, flag and index; the slave drives elem_ready.
interface rom_pair_accum_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              elem_valid;
  logic              elem_ready;
  logic [DATA_W-1:0] elem_data;
  logic              elem_ovf;
  logic [ADDR_W:0]   elem_idx;

  modport master (
    output elem_valid,
    output elem_data,
    output elem_ovf,
    output elem_idx,
    input  elem_ready
  );

  modport slave (
    input  elem_valid,
    input  elem_data,
    input  elem_ovf,
    input  elem_idx,
    output elem_ready
  );
endinterface

// File: rtl/rom_pair_accum.sv
// Walks a run of addresses over two ROMs, adds or subtracts each word pair
// (wrapping or saturating), streams the results and keeps a signed total.
module rom_pair_accum #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int ACC_W  = DATA_W + ADDR_W + 2,
  parameter int RD_LAT = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    mode,
  input  logic                    sat,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [ADDR_W:0]         len,
  output logic [ADDR_W-1:0]       rom1_addr,
  output logic [ADDR_W-1:0]       rom2_addr,
  input  logic [DATA_W-1:0]       rom1_data,
  input  logic [DATA_W-1:0]       rom2_data,
  rom_pair_accum_if.master        elem,
  output logic signed [ACC_W-1:0] acc,
  output logic                    busy,
  output logic                    done
);

  localparam int EXT_W = ACC_W - DATA_W - 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, OUT, DONE} state_t;

  state_t                  state;
  logic                    mode_r;
  logic                    sat_r;
  logic [ADDR_W:0]         len_r;
  logic [DATA_W:0]         raw_r;
  logic [DATA_W:0]         raw_c;
  logic                    ovf_c;
  logic [DATA_W-1:0]       data_c;
  logic signed [ACC_W-1:0] raw_ext;

  // For both add and subtract the top raw bit is exactly the overflow flag.
  always_comb begin
    raw_c  = mode_r ? ({1'b0, rom1_data} - {1'b0, rom2_data})
                    : ({1'b0, rom1_data} + {1'b0, rom2_data});
    ovf_c  = raw_c[DATA_W];
    data_c = raw_c[DATA_W-1:0];
    if (sat_r && ovf_c) begin
      data_c = mode_r ? '0 : '1;
    end
  end

  assign raw_ext   = $signed({{EXT_W{raw_r[DATA_W] & mode_r}}, raw_r});
  assign rom2_addr = rom1_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      mode_r          <= 1'b0;
      sat_r           <= 1'b0;
      len_r           <= '0;
      raw_r           <= '0;
      rom1_addr       <= '0;
      elem.elem_valid <= 1'b0;
      elem.elem_data  <= '0;
      elem.elem_ovf   <= 1'b0;
      elem.elem_idx   <= '0;
      acc             <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mode_r        <= mode;
            sat_r         <= sat;
            len_r         <= len;
            acc           <= '0;
            elem.elem_idx <= '0;
            busy          <= 1'b1;
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              rom1_addr <= base_addr;
            end
          end
        end
        ISSUE: begin
          if (RD_LAT == 0) begin
            raw_r           <= raw_c;
            elem.elem_data  <= data_c;
            elem.elem_ovf   <= ovf_c;
            elem.elem_valid <= 1'b1;
            state           <= OUT;
          end else begin
            state <= WAIT;
          end
        end
        // Block ROM output is valid one cycle after the address register.
        WAIT: begin
          raw_r           <= raw_c;
          elem.elem_data  <= data_c;
          elem.elem_ovf   <= ovf_c;
          elem.elem_valid <= 1'b1;
          state           <= OUT;
        end
        OUT: begin
          if (elem.elem_ready) begin
            elem.elem_valid <= 1'b0;
            acc             <= acc + raw_ext;
            elem.elem_idx   <= elem.elem_idx + (ADDR_W+1)'(1);
            if ((elem.elem_idx + (ADDR_W+1)'(1)) == len_r) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= ISSUE;
              rom1_addr <= rom1_addr + ADDR_W'(1);
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_pair_accum.sv
// Drives two rom_pair_accum instances (asynchronous and registered ROM read)
// through directed runs and scores every streamed element against a model.
module tb_rom_pair_accum;

  typedef struct {
    logic [7:0]         data;
    logic               ovf;
    logic [4:0]         idx;
    logic [3:0]         addr;
    logic signed [13:0] acc_before;
  } exp_t;

  typedef struct {
    logic               valid;
    logic [7:0]         data;
    logic               ovf;
    logic [4:0]         idx;
    logic [3:0]         addr;
    logic [3:0]         addr2;
    logic signed [13:0] acc;
    logic               busy;
    logic               done;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_v [2];
  logic ready_v [2];
  logic mode;
  logic sat;
  logic [3:0] base_addr;
  logic [4:0] len;
  logic [7:0] rom1_mem [16];
  logic [7:0] rom2_mem [16];

  logic [3:0] addr1_0, addr2_0, addr1_1, addr2_1;
  logic [7:0] d1_0, d2_0, d1_1, d2_1;
  logic signed [13:0] acc_0, acc_1;
  logic busy_0, busy_1, done_0, done_1;

  exp_t q0 [$];
  exp_t q1 [$];
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rom_pair_accum_if #(.DATA_W(8), .ADDR_W(4)) elem0 ();
  rom_pair_accum_if #(.DATA_W(8), .ADDR_W(4)) elem1 ();

  assign elem0.elem_ready = ready_v[0];
  assign elem1.elem_ready = ready_v[1];

  // Distributed ROM for instance 0, block ROM for instance 1
  assign d1_0 = rom1_mem[addr1_0];
  assign d2_0 = rom2_mem[addr2_0];

  always @(posedge clk) begin
    d1_1 <= rom1_mem[addr1_1];
    d2_1 <= rom2_mem[addr2_1];
  end

  rom_pair_accum #(.DATA_W(8), .ADDR_W(4), .RD_LAT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .mode(mode), .sat(sat),
    .base_addr(base_addr), .len(len), .rom1_addr(addr1_0), .rom2_addr(addr2_0),
    .rom1_data(d1_0), .rom2_data(d2_0), .elem(elem0), .acc(acc_0),
    .busy(busy_0), .done(done_0)
  );

  rom_pair_accum #(.DATA_W(8), .ADDR_W(4), .RD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .mode(mode), .sat(sat),
    .base_addr(base_addr), .len(len), .rom1_addr(addr1_1), .rom2_addr(addr2_1),
    .rom1_data(d1_1), .rom2_data(d2_1), .elem(elem1), .acc(acc_1),
    .busy(busy_1), .done(done_1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic obs_t observe(input int sel);
    obs_t o;
    if (sel == 0) begin
      o.valid = elem0.elem_valid; o.data = elem0.elem_data; o.ovf = elem0.elem_ovf;
      o.idx = elem0.elem_idx; o.addr = addr1_0; o.addr2 = addr2_0;
      o.acc = acc_0; o.busy = busy_0; o.done = done_0;
    end else begin
      o.valid = elem1.elem_valid; o.data = elem1.elem_data; o.ovf = elem1.elem_ovf;
      o.idx = elem1.elem_idx; o.addr = addr1_1; o.addr2 = addr2_1;
      o.acc = acc_1; o.busy = busy_1; o.done = done_1;
    end
    return o;
  endfunction

  function automatic int qSize(input int sel);
    return (sel == 0) ? q0.size() : q1.size();
  endfunction

  function automatic exp_t qFront(input int sel);
    exp_t e;
    e = '{default: '0};
    if (sel == 0 && q0.size() > 0) e = q0[0];
    if (sel == 1 && q1.size() > 0) e = q1[0];
    return e;
  endfunction

  // Reference arithmetic: element result, flag and running total per address
  task automatic pushRun(input int sel, input bit m, input bit s, input int b,
                         input int l, output int acc_out);
    int   a, bb, raw, addr;
    bit   ovf;
    exp_t e;
    acc_out = 0;
    for (int i = 0; i < l; i++) begin
      addr = (b + i) % 16;
      a    = int'(rom1_mem[addr]);
      bb   = int'(rom2_mem[addr]);
      raw  = m ? (a - bb) : (a + bb);
      ovf  = m ? (a < bb) : (raw > 255);
      e.data       = (s && ovf) ? (m ? 8'd0 : 8'd255) : 8'(raw);
      e.ovf        = ovf;
      e.idx        = 5'(i);
      e.addr       = 4'(addr);
      e.acc_before = 14'(acc_out);
      acc_out += raw;
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  task automatic checkElem(input int sel);
    obs_t o;
    exp_t e;
    o = observe(sel);
    checkOutput($sformatf("lat%0d_elem_expected", sel), 32'(qSize(sel) > 0), 32'd1);
    if (qSize(sel) > 0) begin
      e = (sel == 0) ? q0.pop_front() : q1.pop_front();
      checkOutput($sformatf("lat%0d_elem%0d_data", sel, e.idx), 32'(o.data), 32'(e.data));
      checkOutput($sformatf("lat%0d_elem%0d_ovf", sel, e.idx), 32'(o.ovf), 32'(e.ovf));
      checkOutput($sformatf("lat%0d_elem%0d_idx", sel, e.idx), 32'(o.idx), 32'(e.idx));
      checkOutput($sformatf("lat%0d_elem%0d_addr1", sel, e.idx), 32'(o.addr), 32'(e.addr));
      checkOutput($sformatf("lat%0d_elem%0d_addr2", sel, e.idx), 32'(o.addr2), 32'(e.addr));
      checkOutput($sformatf("lat%0d_elem%0d_acc", sel, e.idx), 32'(o.acc), 32'(e.acc_before));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (elem0.elem_valid && ready_v[0]) checkElem(0);
      if (elem1.elem_valid && ready_v[1]) checkElem(1);
    end
  end

  task automatic checkReset(input int sel, input string pre);
    obs_t o;
    o = observe(sel);
    checkOutput({pre, "_valid"}, 32'(o.valid), 32'd0);
    checkOutput({pre, "_data"},  32'(o.data),  32'd0);
    checkOutput({pre, "_ovf"},   32'(o.ovf),   32'd0);
    checkOutput({pre, "_idx"},   32'(o.idx),   32'd0);
    checkOutput({pre, "_addr1"}, 32'(o.addr),  32'd0);
    checkOutput({pre, "_addr2"}, 32'(o.addr2), 32'd0);
    checkOutput({pre, "_acc"},   32'(o.acc),   32'd0);
    checkOutput({pre, "_busy"},  32'(o.busy),  32'd0);
    checkOutput({pre, "_done"},  32'(o.done),  32'd0);
  endtask

  // One complete run; stall_idx >= 0 holds elem_ready low for 5 cycles there
  task automatic applyStimulus(input int sel, input bit m, input bit s, input int b,
                               input int l, input int stall_idx, input string name);
    int   exp_acc;
    int   n = 0;
    int   first_valid = -1;
    int   done_cnt = 0;
    int   stall_cnt = 0;
    bit   finished = 1'b0;
    bit   stalling;
    obs_t o;
    exp_t f;
    $display("[TB] RD_LAT=%0d run %s", sel, name);
    pushRun(sel, m, s, b, l, exp_acc);
    @(posedge clk); #1;
    mode = m; sat = s; base_addr = 4'(b); len = 5'(l); start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    o = observe(sel);
    checkOutput({name, "_busy_at_start"}, 32'(o.busy), 32'd1);
    if (l != 0) checkOutput({name, "_addr_at_start"}, 32'(o.addr), 32'(b));
    while (!finished && n < 400) begin
      o = observe(sel);
      if (o.valid && first_valid < 0) first_valid = n;
      if (o.done) begin
        done_cnt++;
        checkOutput({name, "_acc_at_done"}, 32'(o.acc), 32'(exp_acc));
      end
      if (done_cnt > 0 && !o.busy) begin
        finished = 1'b1;
      end else begin
        stalling = (stall_idx >= 0) &&
                   ((stall_cnt == 0 && o.valid && o.idx == 5'(stall_idx)) ||
                    (stall_cnt > 0 && stall_cnt < 5));
        if (stalling) begin
          f = qFront(sel);
          checkOutput($sformatf("%s_stall%0d_valid", name, stall_cnt), 32'(o.valid), 32'd1);
          checkOutput($sformatf("%s_stall%0d_data", name, stall_cnt), 32'(o.data), 32'(f.data));
          checkOutput($sformatf("%s_stall%0d_idx", name, stall_cnt), 32'(o.idx), 32'(stall_idx));
          checkOutput($sformatf("%s_stall%0d_addr", name, stall_cnt), 32'(o.addr), 32'(f.addr));
          checkOutput($sformatf("%s_stall%0d_acc", name, stall_cnt), 32'(o.acc), 32'(f.acc_before));
          ready_v[sel] = 1'b0;
          stall_cnt++;
          if (stall_cnt == 2) begin
            start_v[sel] = 1'b1;
            base_addr    = 4'(b + 7);
            mode         = ~m;
            len          = 5'd1;
          end else begin
            start_v[sel] = 1'b0;
          end
        end else begin
          ready_v[sel] = 1'b1;
          start_v[sel] = 1'b0;
        end
        @(posedge clk); #1;
        n++;
      end
    end
    ready_v[sel] = 1'b1;
    checkOutput({name, "_done_pulses"}, 32'(done_cnt), 32'd1);
    checkOutput({name, "_done_after"}, 32'(o.done), 32'd0);
    checkOutput({name, "_busy_after"}, 32'(o.busy), 32'd0);
    checkOutput({name, "_acc_final"}, 32'(o.acc), 32'(exp_acc));
    checkOutput({name, "_first_valid_cycle"}, 32'(first_valid), (l == 0) ? 32'hffffffff : 32'(1 + sel));
    checkOutput({name, "_queue_drained"}, 32'(qSize(sel)), 32'd0);
    if (stall_idx >= 0) checkOutput({name, "_stall_cycles"}, 32'(stall_cnt), 32'd5);
  endtask

  task automatic resetMidRun(input int sel);
    int   dummy;
    int   n = 0;
    bit   reached = 1'b0;
    obs_t o;
    $display("[TB] RD_LAT=%0d reset during element 2", sel);
    pushRun(sel, 1'b0, 1'b0, 0, 3, dummy);
    @(posedge clk); #1;
    mode = 1'b0; sat = 1'b0; base_addr = 4'd0; len = 5'd3; start_v[sel] = 1'b1;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    while (!reached && n < 100) begin
      o = observe(sel);
      if (o.valid && o.idx == 5'd2) reached = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    checkOutput("mid_reset_reached_elem2", 32'(reached), 32'd1);
    #2 rst_n = 1'b0;
    #1 checkReset(sel, $sformatf("lat%0d_mid_reset", sel));
    if (sel == 0) q0.delete();
    else          q1.delete();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    start_v[0] = 1'b0; start_v[1] = 1'b0;
    ready_v[0] = 1'b1; ready_v[1] = 1'b1;
    mode = 1'b0; sat = 1'b0; base_addr = '0; len = '0;
    for (int i = 0; i < 16; i++) begin
      rom1_mem[i] = 8'(17 * i);
      rom2_mem[i] = 8'(17 * i);
    end
    #2 rst_n = 1'b0;
    #1 checkReset(0, "lat0_por");
    checkReset(1, "lat1_por");
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int sel = 0; sel < 2; sel++) begin
      applyStimulus(sel, 1'b0, 1'b0, 2, 3, -1, $sformatf("lat%0d_basic_add", sel));
      applyStimulus(sel, 1'b0, 1'b1, 14, 4, -1, $sformatf("lat%0d_add_sat", sel));
      applyStimulus(sel, 1'b0, 1'b0, 14, 4, -1, $sformatf("lat%0d_add_wrap", sel));
      for (int i = 0; i < 16; i++) rom2_mem[i] = 8'(17 * (15 - i));
      applyStimulus(sel, 1'b1, 1'b1, 7, 2, -1, $sformatf("lat%0d_sub_sat", sel));
      applyStimulus(sel, 1'b1, 1'b0, 7, 2, -1, $sformatf("lat%0d_sub_wrap", sel));
      for (int i = 0; i < 16; i++) rom2_mem[i] = 8'(17 * i);
      applyStimulus(sel, 1'b0, 1'b0, 0, 3, 1, $sformatf("lat%0d_backpressure", sel));
      applyStimulus(sel, 1'b0, 1'b0, 0, 0, -1, $sformatf("lat%0d_len0", sel));
      applyStimulus(sel, 1'b0, 1'b0, 5, 16, -1, $sformatf("lat%0d_full_wrap", sel));
      resetMidRun(sel);
      applyStimulus(sel, 1'b0, 1'b0, 2, 3, -1, $sformatf("lat%0d_after_reset", sel));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
